mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 46 ++++
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/MEM inputs and MEM/WB outputs of the memory stage, plus optional statistics (MEM_STAGE_STATS_EN)
interface mem_stage_if;
    logic [31:0] ex_ALU_result;
    logic [31:0] ex_write_data;
    logic [4:0]  ex_write_reg;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic        ex_MemtoReg;
    logic        ex_RegWrite;
    logic        ex_Branch;
    logic        ex_zero;
    logic        stall;
    logic        flush;
    logic [31:0] mem_Read_data;
    logic [31:0] mem_ALU_result;
    logic [4:0]  mem_write_reg;
    logic        MemtoReg;
    logic        RegWrite;
    logic        PCSrc;
    logic        mem_busy;
    logic        misaligned;
`ifdef MEM_STAGE_STATS_EN
    logic [15:0] load_count;
    logic [15:0] store_count;
`endif

    modport master (
        output ex_ALU_result, ex_write_data, ex_write_reg, ex_MemRead, ex_MemWrite,
               ex_MemtoReg, ex_RegWrite, ex_Branch, ex_zero, stall, flush,
        input  mem_Read_data, mem_ALU_result, mem_write_reg, MemtoReg, RegWrite,
               PCSrc, mem_busy, misaligned
`ifdef MEM_STAGE_STATS_EN
        , input load_count, store_count
`endif
    );

    modport slave (
        input  ex_ALU_result, ex_write_data, ex_write_reg, ex_MemRead, ex_MemWrite,
               ex_MemtoReg, ex_RegWrite, ex_Branch, ex_zero, stall, flush,
        output mem_Read_data, mem_ALU_result, mem_write_reg, MemtoReg, RegWrite,
               PCSrc, mem_busy, misaligned
`ifdef MEM_STAGE_STATS_EN
        , output load_count, store_count
`endif
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: 256x32 data RAM, 2-cycle loads, MEM/WB latch
// Optional load/store counters are built when MEM_STAGE_STATS_EN is defined.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_mem [0:255] = '{default: '0};
    logic [31:0] r_rdata, r_hold_alu;
    logic [4:0]  r_hold_reg;
    logic        r_hold_m2r, r_hold_rw;
    logic [31:0] r_lat_rdata, r_lat_alu, w_lat_rdata, w_lat_alu;
    logic [4:0]  r_lat_reg, w_lat_reg;
    logic        r_lat_m2r, r_lat_rw, w_lat_m2r, w_lat_rw;
    logic        r_misaligned;

    wire [7:0] w_idx        = bus.ex_ALU_result[9:2];
    wire       w_misaligned = (bus.ex_MemRead | bus.ex_MemWrite) & (|bus.ex_ALU_result[1:0]);
    wire       w_advance    = ~bus.stall & ~bus.flush;
    wire       w_idle       = (r_state == S_IDLE);
    wire       w_load_go    = w_idle & bus.ex_MemRead & ~w_misaligned;
    wire       w_store_go   = w_idle & bus.ex_MemWrite & ~bus.ex_MemRead & ~w_misaligned;

    assign bus.PCSrc          = bus.ex_Branch & bus.ex_zero;
    assign bus.mem_busy       = ~rst & ~bus.flush & w_load_go;
    assign bus.mem_Read_data  = r_lat_rdata;
    assign bus.mem_ALU_result = r_lat_alu;
    assign bus.mem_write_reg  = r_lat_reg;
    assign bus.MemtoReg       = r_lat_m2r;
    assign bus.RegWrite       = r_lat_rw;
    assign bus.misaligned     = r_misaligned;

    always_comb begin
        w_state_next = r_state;
        if (bus.flush)
            w_state_next = S_IDLE;
        else if (!bus.stall) begin
            case (r_state)
                S_IDLE:  w_state_next = w_load_go ? S_WAIT : S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Next latch contents while advancing; bubble unless a case fills it in.
    always_comb begin
        w_lat_rdata = '0;
        w_lat_alu   = '0;
        w_lat_reg   = '0;
        w_lat_m2r   = 1'b0;
        w_lat_rw    = 1'b0;
        if (r_state == S_WAIT) begin
            w_lat_rdata = r_rdata;
            w_lat_alu   = r_hold_alu;
            w_lat_reg   = r_hold_reg;
            w_lat_m2r   = r_hold_m2r;
            w_lat_rw    = r_hold_rw;
        end else if (!w_misaligned && !bus.ex_MemRead) begin
            w_lat_alu   = bus.ex_ALU_result;
            w_lat_reg   = bus.ex_write_reg;
            w_lat_m2r   = bus.ex_MemtoReg;
            w_lat_rw    = bus.ex_RegWrite & ~bus.ex_MemWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rdata      <= '0;
            r_hold_alu   <= '0;
            r_hold_reg   <= '0;
            r_hold_m2r   <= 1'b0;
            r_hold_rw    <= 1'b0;
            r_lat_rdata  <= '0;
            r_lat_alu    <= '0;
            r_lat_reg    <= '0;
            r_lat_m2r    <= 1'b0;
            r_lat_rw     <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_misaligned <= w_advance & w_idle & w_misaligned;
            if (bus.flush) begin
                r_lat_rdata <= '0;
                r_lat_alu   <= '0;
                r_lat_reg   <= '0;
                r_lat_m2r   <= 1'b0;
                r_lat_rw    <= 1'b0;
            end else if (!bus.stall) begin
                r_lat_rdata <= w_lat_rdata;
                r_lat_alu   <= w_lat_alu;
                r_lat_reg   <= w_lat_reg;
                r_lat_m2r   <= w_lat_m2r;
                r_lat_rw    <= w_lat_rw;
                if (w_load_go) begin
                    r_rdata    <= r_mem[w_idx];
                    r_hold_alu <= bus.ex_ALU_result;
                    r_hold_reg <= bus.ex_write_reg;
                    r_hold_m2r <= bus.ex_MemtoReg;
                    r_hold_rw  <= bus.ex_RegWrite;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_advance && w_store_go)
            r_mem[w_idx] <= bus.ex_write_data;
    end

`ifdef MEM_STAGE_STATS_EN
    logic [15:0] r_load_count, r_store_count;

    assign bus.load_count  = r_load_count;
    assign bus.store_count = r_store_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_count  <= '0;
            r_store_count <= '0;
        end else if (w_advance) begin
            if (r_state == S_WAIT && r_load_count != 16'hFFFF)
                r_load_count <= r_load_count + 16'd1;
            if (w_store_go && r_store_count != 16'hFFFF)
                r_store_count <= r_store_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_stage_if bus();
    mem_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic mw, input logic m2r, input logic rw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
        bus.ex_MemRead     = mr;
        bus.ex_MemWrite    = mw;
        bus.ex_MemtoReg    = m2r;
        bus.ex_RegWrite    = rw;
        bus.ex_ALU_result  = alu;
        bus.ex_write_data  = wd;
        bus.ex_write_reg   = wr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".rdata"}, bus.mem_Read_data, 32'h0);
        check({tag, ".alu"},   bus.mem_ALU_result, 32'h0);
        check({tag, ".wreg"},  {27'h0, bus.mem_write_reg}, 32'h0);
        check({tag, ".m2r"},   {31'h0, bus.MemtoReg}, 32'h0);
        check({tag, ".rw"},    {31'h0, bus.RegWrite}, 32'h0);
    endtask

    initial begin
        bus.ex_Branch = 1'b0;
        bus.ex_zero   = 1'b0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd1);
        #1;
        check("rst_busy", {31'h0, bus.mem_busy}, 32'h0);
        tick();
        tick();
        check_bubble("rst");
        check("rst_mis", {31'h0, bus.misaligned}, 32'h0);
`ifdef MEM_STAGE_STATS_EN
        check("rst_lcnt", {16'h0, bus.load_count}, 32'h0);
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        rst = 1'b0;

        // store DEADBEEF @0x10, then load it back
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd5);
        #1;
        check("st_busy", {31'h0, bus.mem_busy}, 32'h0);
        tick();
        check("st_rw",  {31'h0, bus.RegWrite}, 32'h0);
        check("st_alu", bus.mem_ALU_result, 32'h10);
        check("st_mem", dut.r_mem[4], 32'hDEADBEEF);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd7);
        #1;
        check("ld_busy", {31'h0, bus.mem_busy}, 32'h1);
        tick();
        check("ld_busy_wait", {31'h0, bus.mem_busy}, 32'h0);
        check_bubble("ld_wait");
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        check("ld_rdata", bus.mem_Read_data, 32'hDEADBEEF);
        check("ld_m2r",   {31'h0, bus.MemtoReg}, 32'h1);
        check("ld_rw",    {31'h0, bus.RegWrite}, 32'h1);
        check("ld_wreg",  {27'h0, bus.mem_write_reg}, 32'd7);
        check("ld_alu",   bus.mem_ALU_result, 32'h10);

        // misaligned load and store
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0, 5'd2);
        #1;
        check("mis_busy", {31'h0, bus.mem_busy}, 32'h0);
        tick();
        check("mis_pulse", {31'h0, bus.misaligned}, 32'h1);
        check_bubble("mis");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h12, 32'h12345678, 5'd0);
        tick();
        check("mis_st_mem", dut.r_mem[4], 32'hDEADBEEF);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        check("mis_end", {31'h0, bus.misaligned}, 32'h0);

        // branch decision
        bus.ex_Branch = 1'b1;
        bus.ex_zero   = 1'b1;
        #1;
        check("pcsrc_taken", {31'h0, bus.PCSrc}, 32'h1);
        bus.ex_zero = 1'b0;
        #1;
        check("pcsrc_not", {31'h0, bus.PCSrc}, 32'h0);
        bus.ex_Branch = 1'b0;

        // plain ALU op
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hABC, 32'h0, 5'd9);
        tick();
        check("alu_val",   bus.mem_ALU_result, 32'hABC);
        check("alu_rw",    {31'h0, bus.RegWrite}, 32'h1);
        check("alu_rdata", bus.mem_Read_data, 32'h0);
        check("alu_wreg",  {27'h0, bus.mem_write_reg}, 32'd9);

        // stalled store
        bus.stall = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h5, 5'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_mem", dut.r_mem[8], 32'h0);
            check("stall_alu", bus.mem_ALU_result, 32'hABC);
        end
        bus.stall = 1'b0;
        tick();
        check("rel_mem", dut.r_mem[8], 32'h5);
        check("rel_alu", bus.mem_ALU_result, 32'h20);
        check("rel_rw",  {31'h0, bus.RegWrite}, 32'h0);

        // flush aborting WAIT
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd7);
        tick();
        bus.flush = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        bus.flush = 1'b0;
        check_bubble("flush");
        check("flush_busy", {31'h0, bus.mem_busy}, 32'h0);
`ifdef MEM_STAGE_STATS_EN
        check("cnt_load",  {16'h0, bus.load_count}, 32'd1);
        check("cnt_store", {16'h0, bus.store_count}, 32'd2);
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 5'd6);
        tick();
        check("flush_idle", bus.mem_ALU_result, 32'h55);

        // reset in WAIT
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 5'd4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_bubble("rst_wait");
        check("rst_wait_mis", {31'h0, bus.misaligned}, 32'h0);
`ifdef MEM_STAGE_STATS_EN
        check("rst_cnt_load",  {16'h0, bus.load_count}, 32'h0);
        check("rst_cnt_store", {16'h0, bus.store_count}, 32'h0);
`endif
        #1;
        check("post_rst_busy", {31'h0, bus.mem_busy}, 32'h1);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        check("post_rst_rdata", bus.mem_Read_data, 32'h5);
        check("post_rst_wreg",  {27'h0, bus.mem_write_reg}, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
